instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32: instruction and PC width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: word-address width of instruction memory.
REQ-003 SHALL have parameter RESET_PC, default 32'h0: byte PC loaded on reset, 4-byte aligned.
REQ-004 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port fetch_en, input, 1: permits new memory reads when 1.
REQ-007 SHALL have port redirect_valid, input, 1: branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, WORD_SIZE: redirect target byte address.
REQ-009 SHALL have port mem_rden, output, 1: read strobe to synchronous instruction memory.
REQ-010 SHALL have port mem_address, output, ADDR_WIDTH: word address, always pc[ADDR_WIDTH+1:2].
REQ-011 SHALL have port mem_q, input, WORD_SIZE: memory read data, valid exactly 1 cycle after the mem_rden cycle.
REQ-012 SHALL have port instr_valid, output, 1: instr/instr_pc hold a valid fetched word.
REQ-013 SHALL have port instr_ready, input, 1: decoder accepts the word when instr_valid=1.
REQ-014 SHALL have port instr, output, WORD_SIZE: fetched instruction at FIFO head.
REQ-015 SHALL have port instr_pc, output, WORD_SIZE: byte PC of instr.
REQ-016 SHALL have port fetch_error, output, 1: sticky misaligned-redirect flag.

Function
REQ-017 SHALL keep a 2-entry FIFO of {instr, pc}, a next-fetch PC register, and an in-flight bit (read issued last cycle, not killed).
REQ-018 SHALL have states RUN and HALT; reset enters RUN; RUN->HALT on a redirect with redirect_pc[1:0]!=0; HALT exits only on reset.
REQ-019 SHALL assert mem_rden in RUN when fetch_en=1, redirect_valid=0, and (count + inflight - pop) < 2, where pop = instr_valid & instr_ready.
REQ-020 SHALL, on each mem_rden cycle, advance pc by 4, modulo 2^WORD_SIZE, with mem_address wrapping naturally.
REQ-021 SHALL push {mem_q, pc of that read} into the FIFO in the cycle after an unkilled read, with no lookup or extra stage.
REQ-022 SHALL drive instr_valid = (count != 0); instr and instr_pc from head; pop on instr_valid & instr_ready.
REQ-023 SHALL support simultaneous push and pop in one cycle, count unchanged, sustaining 1 instruction/cycle.
REQ-024 SHALL hold instr and instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-025 SHALL, on redirect_valid=1 in cycle N: clear FIFO, kill the in-flight response, load pc<=redirect_pc, drive mem_rden=0; first new read in N+1; instr_valid no earlier than N+3.
REQ-026 SHALL give redirect priority over a same-cycle pop and push: both discarded.
REQ-027 SHALL, on a misaligned redirect: set fetch_error=1, flush as in REQ-025, enter HALT; in HALT mem_rden=0 and instr_valid=0.
REQ-028 SHALL ignore redirect_valid while in HALT.
REQ-029 SHALL, with fetch_en=0, issue no reads; the in-flight response and FIFO contents still complete and drain.
REQ-030 SHALL never overflow the FIFO; any push into a full FIFO is a design error and is asserted against in verification.
REQ-031 SHALL, from reset release (first cycle rst=0 = cycle 0, fetch_en=1), issue RESET_PC in cycle 0 and raise instr_valid in cycle 2.

Reset
REQ-032 SHALL, while rst=1 at a clock edge, set: pc=RESET_PC, count=0, inflight=0, state=RUN, fetch_error=0, instr=0, instr_pc=0.
REQ-033 SHALL drive instr_valid=0 and mem_rden=0 in every cycle rst=1.
REQ-034 SHALL, on reset mid-operation, discard FIFO contents and any in-flight response; the mem_q of the cycle following reset is not pushed.

Verification
REQ-035 SHALL cover reset-release: RESET_PC=0, memory word k=k+100, instr_ready=1 -> instr_valid from cycle 2; pc 0,4,8,... with instr 100,101,102,... every cycle.
REQ-036 SHALL cover backpressure: instr_ready=0 for 5 cycles after first valid -> count reaches 2, mem_rden=0, instr stays 100/pc 0; on release 100,101,102 in order with no gap or duplicate.
REQ-037 SHALL cover redirect: redirect_pc=0x40 in cycle N with FIFO full and a read in flight -> mem_rden=0 in N; mem_address=0x10 in N+1; next instr_pc=0x40 in N+3; no stale word emitted.
REQ-038 SHALL cover misaligned redirect: redirect_pc=0x42 -> fetch_error=1 next cycle, instr_valid=0 and mem_rden=0 thereafter; a later redirect to 0x80 is ignored; rst clears all.
REQ-039 SHALL cover wrap: RESET_PC=0x3FFFC, ADDR_WIDTH=16 -> mem_address 0xFFFF then 0x0000; instr_pc 0x3FFFC then 0x40000.
REQ-040 SHALL cover reset mid-stream: rst=1 for 1 cycle with count=2 and a read in flight -> instr_valid=0 the next cycle; the first instr afterward has instr_pc=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Bundles the fetch unit's redirect control, its instruction-memory port and the decoder handshake.
// The master side is the fetch unit; the slave side is its environment.
interface instruction_fetch_unit_if #(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                  fetch_en;
    logic                  redirect_valid;
    logic [WORD_SIZE-1:0]  redirect_pc;
    logic                  mem_rden;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [WORD_SIZE-1:0]  mem_q;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [WORD_SIZE-1:0]  instr;
    logic [WORD_SIZE-1:0]  instr_pc;
    logic                  fetch_error;

    modport master (
        input  fetch_en, redirect_valid, redirect_pc, mem_q, instr_ready,
        output mem_rden, mem_address, instr_valid, instr, instr_pc, fetch_error
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_pc, mem_q, instr_ready,
        input  mem_rden, mem_address, instr_valid, instr, instr_pc, fetch_error
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads a synchronous instruction memory and queues up to two
// {instr, pc} pairs for the decoder. It handles redirects and halts on a misaligned target.
module instruction_fetch_unit #(
    parameter int                   WORD_SIZE  = 32,
    parameter int                   ADDR_WIDTH = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC   = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    instruction_fetch_unit_if.master bus
);
    typedef enum logic {RUN, HALT} state_t;

    state_t               state, state_nxt;
    logic [WORD_SIZE-1:0] pc_p0;
    logic                 inflight_p1;
    logic [WORD_SIZE-1:0] inflight_pc_p1;
    logic [1:0]           count;
    logic [WORD_SIZE-1:0] head_instr, head_pc, tail_instr, tail_pc;
    logic                 fetch_error_r;

    logic                 valid, pop, push, rden, take_redirect, misaligned;
    logic [2:0]           occupancy;

    assign misaligned = (bus.redirect_pc[1:0] != 2'b00);
    assign valid      = (count != 2'd0) && (state == RUN) && !rst;
    assign pop        = valid && bus.instr_ready;
    assign push       = inflight_p1;
    assign occupancy  = {1'b0, count} + {2'b00, inflight_p1};

    always_comb begin
        state_nxt     = state;
        rden          = 1'b0;
        take_redirect = 1'b0;
        case (state)
            RUN: begin
                if (bus.redirect_valid) begin
                    take_redirect = 1'b1;
                    if (misaligned) state_nxt = HALT;
                end else if (bus.fetch_en && !rst && (occupancy < (3'd2 + {2'b00, pop}))) begin
                    // Occupancy counts the outstanding read, so the queue can never overflow.
                    rden = 1'b1;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Stage p0: issue the read and advance the PC. Stage p1: the returning word enters the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0         <= RESET_PC;
            count         <= 2'd0;
            inflight_p1   <= 1'b0;
            fetch_error_r <= 1'b0;
            head_instr    <= '0;
            head_pc       <= '0;
        end else if (take_redirect) begin
            // The redirect wins over any same-cycle push or pop.
            pc_p0       <= bus.redirect_pc;
            count       <= 2'd0;
            inflight_p1 <= 1'b0;
            if (misaligned) fetch_error_r <= 1'b1;
        end else begin
            inflight_p1 <= rden;
            if (rden) begin
                pc_p0          <= pc_p0 + WORD_SIZE'(4);
                inflight_pc_p1 <= pc_p0;
            end
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_instr <= bus.mem_q;
                        head_pc    <= inflight_pc_p1;
                    end else begin
                        tail_instr <= bus.mem_q;
                        tail_pc    <= inflight_pc_p1;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_instr <= tail_instr;
                    head_pc    <= tail_pc;
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_instr <= bus.mem_q;
                        head_pc    <= inflight_pc_p1;
                    end else begin
                        head_instr <= tail_instr;
                        head_pc    <= tail_pc;
                        tail_instr <= bus.mem_q;
                        tail_pc    <= inflight_pc_p1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_rden    = rden;
    assign bus.mem_address = pc_p0[ADDR_WIDTH+1:2];
    assign bus.instr_valid = valid;
    assign bus.instr       = head_instr;
    assign bus.instr_pc    = head_pc;
    assign bus.fetch_error = fetch_error_r;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: memory word k holds k+100.
// A second instance starts near the top of the address space to exercise wrap-around.
module tb_instruction_fetch_unit;
    localparam int WS = 32;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) bus ();
    instruction_fetch_unit_if #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) wbus ();

    instruction_fetch_unit #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    instruction_fetch_unit #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .RESET_PC(32'h3FFFC)) u_wrap (
        .clk(clk), .rst(rst), .bus(wbus)
    );

    always @(posedge clk) begin
        if (bus.mem_rden)  bus.mem_q  <= 32'(bus.mem_address) + 32'd100;
        if (wbus.mem_rden) wbus.mem_q <= 32'(wbus.mem_address) + 32'd100;
    end

    always @(posedge clk) begin
        if (!rst && dut.push && dut.count == 2'd2 && !dut.pop) begin
            n_checks++; n_fail++;
            $display("FAIL fifo_overflow: push into full queue at %0t", $time);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.fetch_en = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid); end
        n_checks++; if (bus.mem_rden !== 1'b0) begin n_fail++; $display("FAIL rst_rden: got %b want 0", bus.mem_rden); end
        n_checks++; if (bus.fetch_error !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.fetch_error); end
        n_checks++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %0h want 0", bus.instr); end
        n_checks++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %0h want 0", bus.instr_pc); end
    endtask

    task automatic test_stream();
        do_reset();
        @(negedge clk);
        n_checks++; if (bus.mem_rden !== 1'b1 || bus.mem_address !== 16'h0) begin n_fail++; $display("FAIL stream_c0: rden=%b addr=%0h want 1/0", bus.mem_rden, bus.mem_address); end
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c0_valid: got %b want 0", bus.instr_valid); end
        tick(); @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b0 || bus.mem_address !== 16'h1) begin n_fail++; $display("FAIL stream_c1: valid=%b addr=%0h want 0/1", bus.instr_valid, bus.mem_address); end
        for (int k = 0; k < 8; k++) begin
            tick(); @(negedge clk);
            n_checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== 32'(100 + k) || bus.instr_pc !== 32'(4 * k)) begin
                n_fail++; $display("FAIL stream_k%0d: valid=%b instr=%0d pc=%0h want 1/%0d/%0h", k, bus.instr_valid, bus.instr, bus.instr_pc, 100 + k, 4 * k);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.instr_ready = 1'b0;
        tick();
        for (int c = 2; c <= 6; c++) begin
            tick(); @(negedge clk);
            n_checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== 32'd100 || bus.instr_pc !== 32'h0 || bus.mem_rden !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_c%0d: valid=%b instr=%0d pc=%0h rden=%b want 1/100/0/0", c, bus.instr_valid, bus.instr, bus.instr_pc, bus.mem_rden);
            end
            if (c >= 3) begin
                n_checks++; if (dut.count !== 2'd2) begin n_fail++; $display("FAIL bp_count_c%0d: got %0d want 2", c, dut.count); end
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick(); bus.instr_ready = 1'b1; @(negedge clk);
            n_checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== 32'(100 + k) || bus.instr_pc !== 32'(4 * k)) begin
                n_fail++; $display("FAIL bp_drain_k%0d: valid=%b instr=%0d pc=%0h want 1/%0d/%0h", k, bus.instr_valid, bus.instr, bus.instr_pc, 100 + k, 4 * k);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (5) tick();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
        @(negedge clk);
        n_checks++; if (bus.mem_rden !== 1'b0 || dut.inflight_p1 !== 1'b1) begin n_fail++; $display("FAIL redir_n: rden=%b inflight=%b want 0/1", bus.mem_rden, dut.inflight_p1); end
        tick(); bus.redirect_valid = 1'b0; @(negedge clk);
        n_checks++; if (bus.mem_rden !== 1'b1 || bus.mem_address !== 16'h10 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_n1: rden=%b addr=%0h valid=%b want 1/10/0", bus.mem_rden, bus.mem_address, bus.instr_valid); end
        tick(); @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_n2_stale: valid=%b want 0", bus.instr_valid); end
        tick(); @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h40 || bus.instr !== 32'd116) begin n_fail++; $display("FAIL redir_n3: valid=%b pc=%0h instr=%0d want 1/40/116", bus.instr_valid, bus.instr_pc, bus.instr); end
        tick(); @(negedge clk);
        n_checks++; if (bus.instr_pc !== 32'h44 || bus.instr !== 32'd117) begin n_fail++; $display("FAIL redir_n4: pc=%0h instr=%0d want 44/117", bus.instr_pc, bus.instr); end
        tick(); bus.instr_ready = 1'b0;
        tick();
        tick(); bus.instr_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h20; @(negedge clk);
        n_checks++; if (dut.count !== 2'd2 || bus.mem_rden !== 1'b0) begin n_fail++; $display("FAIL redir_full: count=%0d rden=%b want 2/0", dut.count, bus.mem_rden); end
        tick(); bus.redirect_valid = 1'b0; @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b0 || bus.mem_address !== 16'h8) begin n_fail++; $display("FAIL redir_full_n1: valid=%b addr=%0h want 0/8", bus.instr_valid, bus.mem_address); end
        tick(); @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_full_n2: valid=%b want 0", bus.instr_valid); end
        tick(); @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h20 || bus.instr !== 32'd108) begin n_fail++; $display("FAIL redir_full_n3: valid=%b pc=%0h instr=%0d want 1/20/108", bus.instr_valid, bus.instr_pc, bus.instr); end
    endtask

    task automatic test_misaligned();
        do_reset();
        repeat (3) tick();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h42; @(negedge clk);
        n_checks++; if (bus.mem_rden !== 1'b0) begin n_fail++; $display("FAIL mis_n: rden=%b want 0", bus.mem_rden); end
        tick(); bus.redirect_valid = 1'b0; @(negedge clk);
        n_checks++; if (bus.fetch_error !== 1'b1 || bus.instr_valid !== 1'b0 || bus.mem_rden !== 1'b0) begin n_fail++; $display("FAIL mis_n1: err=%b valid=%b rden=%b want 1/0/0", bus.fetch_error, bus.instr_valid, bus.mem_rden); end
        tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h80; @(negedge clk);
        n_checks++; if (bus.mem_rden !== 1'b0) begin n_fail++; $display("FAIL mis_ignore: rden=%b want 0", bus.mem_rden); end
        for (int c = 0; c < 3; c++) begin
            tick(); bus.redirect_valid = 1'b0; @(negedge clk);
            n_checks++;
            if (bus.instr_valid !== 1'b0 || bus.mem_rden !== 1'b0 || bus.fetch_error !== 1'b1) begin
                n_fail++; $display("FAIL mis_halt_c%0d: valid=%b rden=%b err=%b want 0/0/1", c, bus.instr_valid, bus.mem_rden, bus.fetch_error);
            end
        end
        do_reset(); @(negedge clk);
        n_checks++; if (bus.fetch_error !== 1'b0 || bus.mem_rden !== 1'b1 || bus.mem_address !== 16'h0) begin n_fail++; $display("FAIL mis_rst: err=%b rden=%b addr=%0h want 0/1/0", bus.fetch_error, bus.mem_rden, bus.mem_address); end
        tick(); tick(); @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL mis_rst_run: valid=%b pc=%0h want 1/0", bus.instr_valid, bus.instr_pc); end
    endtask

    task automatic test_wrap();
        do_reset(); @(negedge clk);
        n_checks++; if (wbus.mem_rden !== 1'b1 || wbus.mem_address !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_c0: rden=%b addr=%0h want 1/ffff", wbus.mem_rden, wbus.mem_address); end
        tick(); @(negedge clk);
        n_checks++; if (wbus.mem_address !== 16'h0000) begin n_fail++; $display("FAIL wrap_c1: addr=%0h want 0", wbus.mem_address); end
        tick(); @(negedge clk);
        n_checks++; if (wbus.instr_valid !== 1'b1 || wbus.instr_pc !== 32'h3FFFC || wbus.instr !== 32'h10063) begin n_fail++; $display("FAIL wrap_c2: valid=%b pc=%0h instr=%0h want 1/3fffc/10063", wbus.instr_valid, wbus.instr_pc, wbus.instr); end
        tick(); @(negedge clk);
        n_checks++; if (wbus.instr_pc !== 32'h40000 || wbus.instr !== 32'd100) begin n_fail++; $display("FAIL wrap_c3: pc=%0h instr=%0d want 40000/100", wbus.instr_pc, wbus.instr); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        repeat (4) tick();
        @(negedge clk);
        n_checks++; if (dut.count === 2'd0 || dut.inflight_p1 !== 1'b1) begin n_fail++; $display("FAIL mid_pre: count=%0d inflight=%b want nonzero/1", dut.count, dut.inflight_p1); end
        tick(); rst = 1'b1; @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b0 || bus.mem_rden !== 1'b0) begin n_fail++; $display("FAIL mid_rst: valid=%b rden=%b want 0/0", bus.instr_valid, bus.mem_rden); end
        tick(); rst = 1'b0; @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b0 || bus.mem_rden !== 1'b1 || bus.mem_address !== 16'h0) begin n_fail++; $display("FAIL mid_c0: valid=%b rden=%b addr=%0h want 0/1/0", bus.instr_valid, bus.mem_rden, bus.mem_address); end
        tick(); @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_c1_stale: valid=%b want 0", bus.instr_valid); end
        tick(); @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.instr !== 32'd100) begin n_fail++; $display("FAIL mid_c2: valid=%b pc=%0h instr=%0d want 1/0/100", bus.instr_valid, bus.instr_pc, bus.instr); end
    endtask

    initial begin
        bus.fetch_en = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b1; bus.mem_q = '0;
        wbus.fetch_en = 1'b1; wbus.redirect_valid = 1'b0; wbus.redirect_pc = '0; wbus.instr_ready = 1'b1; wbus.mem_q = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
